// File: rtl/exu_redirect_arbiter.sv
// exu_redirect_arbiter: oldest-mispredict branch redirect arbiter with a blocking window
module exu_redirect_arbiter #(
  parameter int NUM_CH      = 4,
  parameter int ROB_WIDTH   = 6,
  parameter int FSQ_WIDTH   = 4,
  parameter int PC_WIDTH    = 32,
  parameter int PIPE_STAGES = 1,
  parameter int FLUSH_LAT   = 3,
  localparam int RW = ROB_WIDTH + 1,
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int BW = (FLUSH_LAT > 1) ? $clog2(FLUSH_LAT) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NUM_CH-1:0]        in_valid_i,
  input  logic [NUM_CH-1:0]        in_mispred_i,
  input  logic [NUM_CH*RW-1:0]     in_rob_idx_i,
  input  logic [NUM_CH*FSQ_WIDTH-1:0] in_fsq_idx_i,
  input  logic [NUM_CH*PC_WIDTH-1:0]  in_target_i,
  input  logic                     flush_valid_i,
  input  logic [RW-1:0]            flush_rob_idx_i,
  output logic                     redirect_valid_o,
  output logic [RW-1:0]            redirect_rob_idx_o,
  output logic [FSQ_WIDTH-1:0]     redirect_fsq_idx_o,
  output logic [PC_WIDTH-1:0]      redirect_target_o,
  output logic [CW-1:0]            redirect_ch_o,
  output logic [15:0]              drop_cnt_o
);
  // The dir bit flips on each ROB wrap, so a differing dir reverses the index order.
  function automatic logic older(input logic [RW-1:0] a, input logic [RW-1:0] b);
    return (a[RW-1] == b[RW-1]) ? (a[RW-2:0] < b[RW-2:0]) : (a[RW-2:0] > b[RW-2:0]);
  endfunction

  function automatic logic killed(input logic [RW-1:0] x, input logic fv, input logic [RW-1:0] fidx,
                                  input logic bv, input logic [RW-1:0] bidx);
    return (fv & ~older(x, fidx)) | (bv & ~older(x, bidx));
  endfunction

  logic                 block_valid_q, block_valid_d;
  logic [RW-1:0]        block_idx_q, block_idx_d;
  logic [BW-1:0]        block_cnt_q, block_cnt_d;
  logic [15:0]          drop_q, drop_d;
  logic                 win_v, drop_hit;
  logic [RW-1:0]        win_rob;
  logic [FSQ_WIDTH-1:0] win_fsq;
  logic [PC_WIDTH-1:0]  win_tgt;
  logic [CW-1:0]        win_ch;
  logic                 s1_v_q;
  logic [RW-1:0]        s1_rob_q;
  logic [FSQ_WIDTH-1:0] s1_fsq_q;
  logic [PC_WIDTH-1:0]  s1_tgt_q;
  logic [CW-1:0]        s1_ch_q;
  logic                 adv_v;
  logic [RW-1:0]        adv_rob;
  logic [FSQ_WIDTH-1:0] adv_fsq;
  logic [PC_WIDTH-1:0]  adv_tgt;
  logic [CW-1:0]        adv_ch;
  logic                 out_v_q;
  logic [RW-1:0]        out_rob_q;
  logic [FSQ_WIDTH-1:0] out_fsq_q;
  logic [PC_WIDTH-1:0]  out_tgt_q;
  logic [CW-1:0]        out_ch_q;

  // Pick the oldest surviving mispredict; strict compare keeps the lowest channel on ties.
  always_comb begin
    win_v    = 1'b0;
    win_rob  = '0;
    win_fsq  = '0;
    win_tgt  = '0;
    win_ch   = '0;
    drop_hit = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (in_valid_i[i] && in_mispred_i[i]) begin
        if (killed(in_rob_idx_i[i*RW +: RW], flush_valid_i, flush_rob_idx_i, block_valid_q, block_idx_q))
          drop_hit = 1'b1;
        else if (!win_v || older(in_rob_idx_i[i*RW +: RW], win_rob)) begin
          win_v   = 1'b1;
          win_rob = in_rob_idx_i[i*RW +: RW];
          win_fsq = in_fsq_idx_i[i*FSQ_WIDTH +: FSQ_WIDTH];
          win_tgt = in_target_i[i*PC_WIDTH +: PC_WIDTH];
          win_ch  = CW'(i);
        end
      end
    end
  end

  // Entry reaching the output register; a staged entry is re-checked against the current kill state.
  always_comb begin
    adv_v   = (PIPE_STAGES == 1) ? win_v
            : s1_v_q & ~killed(s1_rob_q, flush_valid_i, flush_rob_idx_i, block_valid_q, block_idx_q);
    adv_rob = (PIPE_STAGES == 1) ? win_rob : s1_rob_q;
    adv_fsq = (PIPE_STAGES == 1) ? win_fsq : s1_fsq_q;
    adv_tgt = (PIPE_STAGES == 1) ? win_tgt : s1_tgt_q;
    adv_ch  = (PIPE_STAGES == 1) ? win_ch  : s1_ch_q;
    block_valid_d = adv_v | (block_valid_q & ~flush_valid_i & (block_cnt_q != '0));
    block_idx_d   = adv_v ? adv_rob : block_idx_q;
    block_cnt_d   = adv_v ? BW'(FLUSH_LAT - 1) : (block_cnt_q != '0) ? block_cnt_q - 1'b1 : block_cnt_q;
    drop_d        = (drop_hit && drop_q != 16'hFFFF) ? drop_q + 16'd1 : drop_q;
  end

  // Optional select stage, used only when PIPE_STAGES is 2.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s1_v_q   <= 1'b0;
      s1_rob_q <= '0;
      s1_fsq_q <= '0;
      s1_tgt_q <= '0;
      s1_ch_q  <= '0;
    end else begin
      s1_v_q <= win_v;
      if (win_v) begin
        s1_rob_q <= win_rob;
        s1_fsq_q <= win_fsq;
        s1_tgt_q <= win_tgt;
        s1_ch_q  <= win_ch;
      end
    end
  end

  // Output register, blocking window and drop counter.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_v_q       <= 1'b0;
      out_rob_q     <= '0;
      out_fsq_q     <= '0;
      out_tgt_q     <= '0;
      out_ch_q      <= '0;
      block_valid_q <= 1'b0;
      block_idx_q   <= '0;
      block_cnt_q   <= '0;
      drop_q        <= '0;
    end else begin
      out_v_q <= adv_v;
      if (adv_v) begin
        out_rob_q <= adv_rob;
        out_fsq_q <= adv_fsq;
        out_tgt_q <= adv_tgt;
        out_ch_q  <= adv_ch;
      end
      block_valid_q <= block_valid_d;
      block_idx_q   <= block_idx_d;
      block_cnt_q   <= block_cnt_d;
      drop_q        <= drop_d;
    end
  end

  assign redirect_valid_o   = out_v_q;
  assign redirect_rob_idx_o = out_rob_q;
  assign redirect_fsq_idx_o = out_fsq_q;
  assign redirect_target_o  = out_tgt_q;
  assign redirect_ch_o      = out_ch_q;
  assign drop_cnt_o         = drop_q;
endmodule

// File: tb/tb_exu_redirect_arbiter.sv
// tb_exu_redirect_arbiter: checks a 1-stage and a 2-stage arbiter against an age-distance model
module tb_exu_redirect_arbiter;
  localparam int N = 4, RW = 7, FW = 4, PW = 32, FL = 3;

  logic clk = 1'b0, rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic          t_v[N], t_m[N];
  logic [RW-1:0] t_rob[N];
  logic [FW-1:0] t_fsq[N];
  logic [PW-1:0] t_tgt[N];
  logic          flush_valid;
  logic [RW-1:0] flush_rob;
  logic [N-1:0]    p_v, p_m;
  logic [N*RW-1:0] p_rob;
  logic [N*FW-1:0] p_fsq;
  logic [N*PW-1:0] p_tgt;

  always_comb begin
    p_v = '0; p_m = '0; p_rob = '0; p_fsq = '0; p_tgt = '0;
    for (int i = 0; i < N; i++) begin
      p_v[i] = t_v[i]; p_m[i] = t_m[i];
      p_rob[i*RW +: RW] = t_rob[i];
      p_fsq[i*FW +: FW] = t_fsq[i];
      p_tgt[i*PW +: PW] = t_tgt[i];
    end
  end

  logic          rv[2];
  logic [RW-1:0] rrob[2];
  logic [FW-1:0] rfsq[2];
  logic [PW-1:0] rtgt[2];
  logic [1:0]    rch[2];
  logic [15:0]   dcnt[2];

  exu_redirect_arbiter #(.NUM_CH(N), .ROB_WIDTH(6), .FSQ_WIDTH(FW), .PC_WIDTH(PW), .PIPE_STAGES(1), .FLUSH_LAT(FL)) dut (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(p_v), .in_mispred_i(p_m), .in_rob_idx_i(p_rob),
    .in_fsq_idx_i(p_fsq), .in_target_i(p_tgt), .flush_valid_i(flush_valid), .flush_rob_idx_i(flush_rob),
    .redirect_valid_o(rv[0]), .redirect_rob_idx_o(rrob[0]), .redirect_fsq_idx_o(rfsq[0]),
    .redirect_target_o(rtgt[0]), .redirect_ch_o(rch[0]), .drop_cnt_o(dcnt[0]));

  exu_redirect_arbiter #(.NUM_CH(N), .ROB_WIDTH(6), .FSQ_WIDTH(FW), .PC_WIDTH(PW), .PIPE_STAGES(2), .FLUSH_LAT(FL)) dut2 (
    .clk_i(clk), .rst_ni(rst_ni), .in_valid_i(p_v), .in_mispred_i(p_m), .in_rob_idx_i(p_rob),
    .in_fsq_idx_i(p_fsq), .in_target_i(p_tgt), .flush_valid_i(flush_valid), .flush_rob_idx_i(flush_rob),
    .redirect_valid_o(rv[1]), .redirect_rob_idx_o(rrob[1]), .redirect_fsq_idx_o(rfsq[1]),
    .redirect_target_o(rtgt[1]), .redirect_ch_o(rch[1]), .drop_cnt_o(dcnt[1]));

  int n_tests = 0, n_fail = 0;

  // Model state: index 0 mirrors the 1-stage instance, index 1 the 2-stage one.
  bit            m_s1v[2];
  logic [RW-1:0] m_s1rob[2];
  logic [FW-1:0] m_s1fsq[2];
  logic [PW-1:0] m_s1tgt[2];
  logic [1:0]    m_s1ch[2];
  int            m_left[2];
  logic [RW-1:0] m_bidx[2];
  bit            e_v[2];
  logic [RW-1:0] e_rob[2];
  logic [FW-1:0] e_fsq[2];
  logic [PW-1:0] e_tgt[2];
  logic [1:0]    e_ch[2];
  int            e_drop[2];

  // a is older than b when b lies ahead of a by less than half the 128-entry age circle.
  function automatic bit m_older(logic [RW-1:0] a, logic [RW-1:0] b);
    int d = (int'(b) - int'(a)) & 127;
    return d > 0 && d < 64;
  endfunction

  function automatic bit m_killed(int k, logic [RW-1:0] x);
    return (flush_valid && !m_older(x, flush_rob)) || (m_left[k] > 0 && !m_older(x, m_bidx[k]));
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1v[k] = 0; m_s1rob[k] = '0; m_s1fsq[k] = '0; m_s1tgt[k] = '0; m_s1ch[k] = '0;
      m_left[k] = 0; m_bidx[k] = '0;
      e_v[k] = 0; e_rob[k] = '0; e_fsq[k] = '0; e_tgt[k] = '0; e_ch[k] = '0; e_drop[k] = 0;
    end
  endtask

  task automatic model_step();
    bit wv, hit, iv;
    int wc;
    logic [RW-1:0] irob; logic [FW-1:0] ifsq; logic [PW-1:0] itgt; logic [1:0] ich;
    for (int k = 0; k < 2; k++) begin
      wv = 0; hit = 0; wc = 0;
      for (int i = 0; i < N; i++)
        if (t_v[i] && t_m[i]) begin
          if (m_killed(k, t_rob[i])) hit = 1;
          else if (!wv || m_older(t_rob[i], t_rob[wc])) begin wv = 1; wc = i; end
        end
      if (k == 0) begin
        iv = wv; irob = t_rob[wc]; ifsq = t_fsq[wc]; itgt = t_tgt[wc]; ich = 2'(wc);
      end else begin
        iv = m_s1v[1] && !m_killed(1, m_s1rob[1]);
        irob = m_s1rob[1]; ifsq = m_s1fsq[1]; itgt = m_s1tgt[1]; ich = m_s1ch[1];
        m_s1v[1] = wv;
        if (wv) begin m_s1rob[1] = t_rob[wc]; m_s1fsq[1] = t_fsq[wc]; m_s1tgt[1] = t_tgt[wc]; m_s1ch[1] = 2'(wc); end
      end
      e_v[k] = iv;
      if (iv) begin e_rob[k] = irob; e_fsq[k] = ifsq; e_tgt[k] = itgt; e_ch[k] = ich; end
      if (iv) begin m_left[k] = FL; m_bidx[k] = irob; end
      else if (flush_valid) m_left[k] = 0;
      else if (m_left[k] > 0) m_left[k]--;
      if (hit && e_drop[k] < 65535) e_drop[k]++;
    end
  endtask

  task automatic step();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    for (int i = 0; i < N; i++) begin t_v[i] = 0; t_m[i] = 0; t_rob[i] = '0; t_fsq[i] = '0; t_tgt[i] = '0; end
    flush_valid = 0; flush_rob = '0;
  endtask

  task automatic set_ch(int c, logic [RW-1:0] rob);
    t_v[c] = 1; t_m[c] = 1; t_rob[c] = rob; t_fsq[c] = FW'(rob + 7'(c));
    t_tgt[c] = 32'h8000_0000 | (32'(c) << 16) | 32'(rob);
  endtask

  task automatic idle(int n);
    clear_in();
    repeat (n) step();
  endtask

  task automatic test_reset();
    clear_in(); model_reset();
    rst_ni = 0;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (rv[k] !== 0 || rrob[k] !== 0 || rfsq[k] !== 0 || rtgt[k] !== 0 || rch[k] !== 0 || dcnt[k] !== 0) begin
        n_fail++;
        $display("FAIL reset[%0d]: v=%0d rob=%0d fsq=%0d tgt=%h ch=%0d drop=%0d, want all 0", k, rv[k], rrob[k], rfsq[k], rtgt[k], rch[k], dcnt[k]);
      end
    end
    rst_ni = 1;
    idle(2);
  endtask

  task automatic test_oldest();
    idle(5);
    set_ch(1, 7'd5); set_ch(3, 7'd2);
    step();
    n_tests++;
    if (rv[0] !== 1 || rrob[0] !== 7'd2 || rch[0] !== 2'd3 || rtgt[0] !== 32'h8003_0002) begin
      n_fail++;
      $display("FAIL oldest: v=%0d rob=%0d ch=%0d tgt=%h, want 1/2/3/80030002", rv[0], rrob[0], rch[0], rtgt[0]);
    end
    n_tests++;
    if (rv[1] !== 0) begin n_fail++; $display("FAIL oldest_pipe2_early: v=%0d, want 0", rv[1]); end
    clear_in();
    step();
    n_tests++;
    if (rv[1] !== 1 || rrob[1] !== 7'd2 || rch[1] !== 2'd3 || rv[0] !== 0) begin
      n_fail++;
      $display("FAIL oldest_pipe2: v2=%0d rob=%0d ch=%0d v1=%0d, want 1/2/3/0", rv[1], rrob[1], rch[1], rv[0]);
    end
  endtask

  task automatic test_wrap();
    idle(5);
    set_ch(0, 7'h41); set_ch(2, 7'd60);
    t_v[1] = 1; t_m[1] = 0; t_rob[1] = 7'd50;
    step();
    n_tests++;
    if (rv[0] !== 1 || rrob[0] !== 7'd60 || rch[0] !== 2'd2) begin
      n_fail++;
      $display("FAIL wrap: v=%0d rob=%0d ch=%0d, want 1/60/2", rv[0], rrob[0], rch[0]);
    end
  endtask

  task automatic test_block();
    int d0;
    idle(5);
    set_ch(0, 7'd10);
    step();
    d0 = e_drop[0];
    clear_in(); set_ch(0, 7'd12);
    step();
    n_tests++;
    if (rv[0] !== 0 || dcnt[0] !== 16'(d0 + 1)) begin
      n_fail++;
      $display("FAIL block_young: v=%0d drop=%0d, want 0/%0d", rv[0], dcnt[0], d0 + 1);
    end
    clear_in(); set_ch(0, 7'd8);
    step();
    n_tests++;
    if (rv[0] !== 1 || rrob[0] !== 7'd8) begin
      n_fail++;
      $display("FAIL block_older: v=%0d rob=%0d, want 1/8", rv[0], rrob[0]);
    end
    n_tests++;
    if (rv[1] !== 0 || dcnt[1] !== 16'(e_drop[1])) begin
      n_fail++;
      $display("FAIL block_pipe2: v=%0d drop=%0d, want 0/%0d", rv[1], dcnt[1], e_drop[1]);
    end
  endtask

  task automatic test_window_expire();
    idle(6);
    set_ch(0, 7'd10);
    step();
    idle(2);
    set_ch(0, 7'd12);
    step();
    n_tests++;
    if (rv[0] !== 0) begin n_fail++; $display("FAIL window_last: v=%0d, want 0", rv[0]); end
    clear_in(); set_ch(0, 7'd12);
    step();
    n_tests++;
    if (rv[0] !== 1 || rrob[0] !== 7'd12) begin
      n_fail++;
      $display("FAIL window_expired: v=%0d rob=%0d, want 1/12", rv[0], rrob[0]);
    end
  endtask

  task automatic test_pipe2_flush();
    idle(6);
    set_ch(0, 7'd20);
    step();
    clear_in(); flush_valid = 1; flush_rob = 7'd15;
    step();
    n_tests++;
    if (rv[1] !== 0 || rv[0] !== 0) begin
      n_fail++;
      $display("FAIL pipe2_flush: v2=%0d v1=%0d, want 0/0", rv[1], rv[0]);
    end
    clear_in();
    step();
    n_tests++;
    if (rv[1] !== 0 || rrob[1] !== e_rob[1]) begin
      n_fail++;
      $display("FAIL pipe2_flush_after: v=%0d rob=%0d, want 0/%0d", rv[1], rrob[1], e_rob[1]);
    end
  endtask

  task automatic test_random();
    int base = 30;
    idle(6);
    for (int c = 0; c < 400; c++) begin
      clear_in();
      for (int i = 0; i < N; i++)
        if ($urandom_range(0, 2) == 0) begin
          set_ch(i, 7'((base + int'($urandom_range(0, 24))) & 127));
          t_m[i] = ($urandom_range(0, 4) != 0);
        end
      if ($urandom_range(0, 9) == 0) begin flush_valid = 1; flush_rob = 7'((base + int'($urandom_range(0, 24))) & 127); end
      if ($urandom_range(0, 3) == 0) base = (base + 3) & 127;
      step();
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (rv[k] !== e_v[k] || rrob[k] !== e_rob[k] || rfsq[k] !== e_fsq[k] || rtgt[k] !== e_tgt[k] ||
            rch[k] !== e_ch[k] || dcnt[k] !== 16'(e_drop[k])) begin
          n_fail++;
          $display("FAIL random[%0d] c%0d: v=%0d rob=%0d fsq=%0d tgt=%h ch=%0d drop=%0d, want %0d/%0d/%0d/%h/%0d/%0d",
                   k, c, rv[k], rrob[k], rfsq[k], rtgt[k], rch[k], dcnt[k],
                   e_v[k], e_rob[k], e_fsq[k], e_tgt[k], e_ch[k], e_drop[k]);
        end
      end
    end
  endtask

  task automatic test_saturate_reset();
    idle(6);
    flush_valid = 1; flush_rob = 7'd0; set_ch(0, 7'd5);
    while (e_drop[0] < 65534) step();
    n_tests++;
    if (dcnt[0] !== 16'hFFFE) begin n_fail++; $display("FAIL sat_pre: drop=%h, want fffe", dcnt[0]); end
    for (int j = 0; j < 3; j++) begin
      step();
      n_tests++;
      if (dcnt[0] !== 16'hFFFF || dcnt[1] !== 16'(e_drop[1])) begin
        n_fail++;
        $display("FAIL sat[%0d]: drop=%h drop2=%h, want ffff/%h", j, dcnt[0], dcnt[1], 16'(e_drop[1]));
      end
    end
    idle(6);
    set_ch(0, 7'd10);
    step();
    #2 rst_ni = 0;
    #1;
    for (int k = 0; k < 2; k++) begin
      n_tests++;
      if (rv[k] !== 0 || rrob[k] !== 0 || rfsq[k] !== 0 || rtgt[k] !== 0 || rch[k] !== 0 || dcnt[k] !== 0) begin
        n_fail++;
        $display("FAIL async_reset[%0d]: v=%0d rob=%0d tgt=%h drop=%0d, want all 0", k, rv[k], rrob[k], rtgt[k], dcnt[k]);
      end
    end
    clear_in(); model_reset();
    @(posedge clk);
    #1 rst_ni = 1;
    repeat (2) begin
      step();
      n_tests++;
      if (rv[0] !== 0 || rv[1] !== 0) begin
        n_fail++;
        $display("FAIL post_reset_pulse: v1=%0d v2=%0d, want 0/0", rv[0], rv[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_oldest();
    test_wrap();
    test_block();
    test_window_expire();
    test_pipe2_flush();
    test_random();
    test_saturate_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
